ccd_line_capture: RTL and testbench
===================================

// Module: ccd_line_capture
// PURPOSE
//  Downstream of the CCD SH generator: on each SH rising edge, drives ICG low, then sequences
//  one line readout. Issues one ADC convert strobe per pixel and captures the sample; forwards
//  effective (non-dummy) pixels on a valid/ready stream through a 4-entry FIFO.
//  Sits between the CCD timing block and the line-buffer/sugar-analysis datapath.
// PARAMETERS
//  PIX_TOTAL    3694  pixel periods read per line, dummies included
//  DUMMY_LEAD   32    leading dummy pixels, not forwarded
//  DUMMY_TRAIL  14    trailing dummy pixels, not forwarded
//  PIX_DIV      4     Master_clk cycles per pixel (>=3)
//  ICG_LOW      20    Master_clk cycles ICG is held low per frame
//  ADC_W        12    ADC sample width
// PORTS
//  Master_clk   in   1      master clock, all logic on rising edge
//  rst          in   1      synchronous reset, active-high
//  capture_en   in   1      1 = SH rising edges start frames; 0 = edges ignored
//  CCD_SH       in   1      SH pulse from the SH generator, synchronous to Master_clk
//  clr_status   in   1      1-cycle pulse: clears overflow and overrun
//  CCD_ICG      out  1      ICG gate to sensor, idle high
//  adc_convst   out  1      1-cycle ADC convert strobe per pixel
//  adc_data     in   ADC_W  ADC result, valid by phase PIX_DIV-1 of the same pixel
//  pix_data     out  ADC_W  effective pixel sample
//  pix_last     out  1      marks last effective pixel of the line
//  pix_valid    out  1      pix_data/pix_last valid
//  pix_ready    in   1      consumer accepts when pix_valid & pix_ready
//  busy         out  1      1 while in ICG_LO or READOUT
//  frame_done   out  1      1-cycle pulse when readout completes
//  overflow     out  1      sticky: effective sample dropped because FIFO full
//  overrun      out  1      sticky: SH rising edge seen while busy
// BEHAVIOUR
//  Reset: CCD_ICG=1, adc_convst=0, pix_valid=0, pix_last=0, busy=0, frame_done=0,
//   overflow=0, overrun=0. FSM goes to IDLE, FIFO is flushed, sh_d=1 (no spurious edge).
//  Edge detect: sh_rise = CCD_SH & ~sh_d; sh_d is registered every cycle.
//  FSM IDLE -> ICG_LO -> READOUT -> IDLE.
//  - IDLE: if sh_rise & capture_en at cycle T, go to ICG_LO. CCD_ICG=0 for cycles T+1..T+ICG_LOW.
//  - ICG_LO -> READOUT at T+ICG_LOW+1, with CCD_ICG=1, phase=0, pix_idx=0.
//  - READOUT: phase counts 0..PIX_DIV-1 and wraps; pix_idx increments on the wrap.
//    adc_convst=1 exactly when phase==0. At phase==PIX_DIV-1, adc_data is captured and tagged.
//    A sample is effective iff DUMMY_LEAD <= pix_idx < PIX_TOTAL-DUMMY_TRAIL.
//    pix_last=1 iff pix_idx == PIX_TOTAL-DUMMY_TRAIL-1.
//    An effective sample is pushed into the FIFO on the cycle after capture.
//  - Leaving READOUT: after phase PIX_DIV-1 of pix_idx==PIX_TOTAL-1, go to IDLE and
//    pulse frame_done for 1 cycle.
//  Frame length: ICG_LOW + PIX_TOTAL*PIX_DIV cycles from T+1.
//  sh_rise while busy: ignored (no restart); overrun is set.
//  capture_en is sampled only in IDLE; deasserting it mid-frame does not abort the frame.
//  FIFO: 4 entries, each {pix_last, data}. pix_valid = FIFO not empty; pix_data/pix_last show the head.
//   Push when FIFO full (and no pop that cycle): sample is dropped and overflow is set.
//   Push and pop in the same cycle are both allowed.
//   Output holds stable while pix_valid & ~pix_ready.
//  clr_status clears overflow/overrun. If a set event occurs in the same cycle, set wins.
//  rst mid-frame: ICG returns high next cycle and the FIFO contents are discarded.
//  Counters: phase $clog2(PIX_DIV) bits; pix_idx 12 bits (must cover PIX_TOTAL-1); ICG counter 16 bits.
// TESTING
//  Params PIX_TOTAL=10, LEAD=2, TRAIL=1, PIX_DIV=4, ICG_LOW=20; pix_ready=1.
//  1 Nominal: SH rises at cycle 100 with capture_en=1 -> ICG low over 102..121.
//    convst at 122,126,...,158; 7 pixels out, pix_last on the 7th; frame_done at 162.
//  2 Data tagging: adc_data = pix_idx*0x111 -> pix_data sequence 0x222..0x888, no dummies emitted.
//  3 Backpressure: pix_ready=0 for a whole frame -> 4 words held stable, 3 dropped, overflow=1.
//    Then release ready -> 4 words drain in order.
//  4 Overrun: second SH rise 30 cycles after the first -> overrun=1, frame timing unchanged.
//    clr_status pulse -> overrun=0.
//  5 capture_en=0 at SH rise -> ICG stays 1, no convst, busy=0.
//  6 rst asserted at cycle 130 mid-readout -> next cycle ICG=1, pix_valid=0, busy=0.
//    Next SH rise starts a clean frame.

Source files
------------

// File: rtl/ccd_line_capture.sv
// ccd_line_capture: sequences one CCD line readout per SH rising edge and streams effective pixels.
// Ports:
//   Master_clk, rst         clock, synchronous active-high reset
//   capture_en, CCD_SH      frame enable (sampled in IDLE), SH pulse from the SH generator
//   clr_status              clears the sticky overflow/overrun flags
//   CCD_ICG                 ICG gate to the sensor, idle high
//   adc_convst, adc_data    one convert strobe per pixel, sample returned by phase PIX_DIV-1
//   pix_data/last/valid/ready  effective pixel stream out of a 4-entry FIFO
//   busy, frame_done        frame in progress, 1-cycle end-of-readout pulse
//   overflow, overrun       sticky: sample dropped on full FIFO, SH edge while busy
module ccd_line_capture #(
  parameter int PIX_TOTAL   = 3694,
  parameter int DUMMY_LEAD  = 32,
  parameter int DUMMY_TRAIL = 14,
  parameter int PIX_DIV     = 4,
  parameter int ICG_LOW     = 20,
  parameter int ADC_W       = 12
) (
  input  logic             Master_clk,
  input  logic             rst,
  input  logic             capture_en,
  input  logic             CCD_SH,
  input  logic             clr_status,
  output logic             CCD_ICG,
  output logic             adc_convst,
  input  logic [ADC_W-1:0] adc_data,
  output logic [ADC_W-1:0] pix_data,
  output logic             pix_last,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             busy,
  output logic             frame_done,
  output logic             overflow,
  output logic             overrun
);
  localparam int PW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(PIX_DIV - 1);
  localparam logic [15:0]   ICG_END  = 16'(ICG_LOW - 1);
  localparam logic [11:0]   EFF_LO   = 12'(DUMMY_LEAD);
  localparam logic [11:0]   EFF_HI   = 12'(PIX_TOTAL - DUMMY_TRAIL);
  localparam logic [11:0]   EFF_LAST = 12'(PIX_TOTAL - DUMMY_TRAIL - 1);
  localparam logic [11:0]   IDX_LAST = 12'(PIX_TOTAL - 1);

  typedef enum logic [1:0] {IDLE, ICG_LO, READOUT} state_t;
  state_t state, state_nx;

  logic          sh_d, sh_rise;
  logic [PW-1:0] phase;
  logic [11:0]   pix_idx;
  logic [15:0]   icg_cnt;
  logic          pix_end, line_end, eff;
  logic             cap_vld, cap_last;
  logic [ADC_W-1:0] cap_data;
  logic [ADC_W:0]   mem [4];
  logic [1:0]       wp, rp;
  logic [2:0]       cnt;
  logic             push, pop, full, push_ok, drop;

  assign sh_rise    = CCD_SH & ~sh_d;
  assign busy       = state != IDLE;
  assign CCD_ICG    = state != ICG_LO;
  assign adc_convst = state == READOUT && phase == '0;
  assign pix_end    = state == READOUT && phase == PH_LAST;
  assign line_end   = pix_end && pix_idx == IDX_LAST;
  assign eff        = pix_idx >= EFF_LO && pix_idx < EFF_HI;

  always_comb begin
    state_nx = (state == IDLE)   ? ((sh_rise && capture_en) ? ICG_LO : IDLE) :
               (state == ICG_LO) ? ((icg_cnt == ICG_END) ? READOUT : ICG_LO) :
               (state == READOUT) ? (line_end ? IDLE : READOUT) : IDLE;
  end

  // Captured sample is pushed the cycle after capture; a full FIFO only accepts if it is also popping.
  assign push      = cap_vld;
  assign pop       = pix_valid && pix_ready;
  assign full      = cnt == 3'd4;
  assign push_ok   = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign pix_valid = cnt != 3'd0;
  assign pix_data  = mem[rp][ADC_W-1:0];
  assign pix_last  = mem[rp][ADC_W];

  always_ff @(posedge Master_clk) begin
    if (rst) begin
      state      <= IDLE;
      sh_d       <= 1'b1;
      phase      <= '0;
      pix_idx    <= '0;
      icg_cnt    <= '0;
      cap_vld    <= 1'b0;
      cap_last   <= 1'b0;
      cap_data   <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      overrun    <= 1'b0;
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
    end else begin
      state      <= state_nx;
      sh_d       <= CCD_SH;
      icg_cnt    <= (state == ICG_LO) ? icg_cnt + 16'd1 : '0;
      phase      <= (state == READOUT && !pix_end) ? phase + PW'(1) : '0;
      pix_idx    <= (state == READOUT) ? pix_idx + 12'(pix_end) : '0;
      cap_vld    <= pix_end && eff;
      cap_last   <= pix_idx == EFF_LAST;
      cap_data   <= adc_data;
      frame_done <= line_end;
      overflow   <= drop || (overflow && !clr_status);
      overrun    <= (sh_rise && busy) || (overrun && !clr_status);
      wp         <= wp + 2'(push_ok);
      rp         <= rp + 2'(pop);
      cnt        <= cnt + 3'(push_ok) - 3'(pop);
    end
  end

  always_ff @(posedge Master_clk) begin
    if (push_ok) mem[wp] <= {cap_last, cap_data};
  end
endmodule

// File: tb/tb_ccd_line_capture.sv
// tb_ccd_line_capture: directed bench for ccd_line_capture with a short 10-pixel line.
module tb_ccd_line_capture;
  logic        Master_clk = 1'b0;
  logic        rst = 1'b1;
  logic        capture_en = 1'b1;
  logic        CCD_SH = 1'b0;
  logic        clr_status = 1'b0;
  logic        CCD_ICG, adc_convst, pix_last, pix_valid, busy, frame_done, overflow, overrun;
  logic        pix_ready = 1'b1;
  logic [11:0] adc_data, pix_data;
  logic [11:0] conv_seen = '0;

  int n_chk = 0, n_fail = 0;
  int icg_bad, conv_n, conv_bad, done_n, done_at, busy_n, hold_bad = 0, base;
  logic [12:0] got [$];
  logic        pv_q = 1'b0, rdy_q = 1'b0;
  logic [12:0] held = '0;

  ccd_line_capture #(.PIX_TOTAL(10), .DUMMY_LEAD(2), .DUMMY_TRAIL(1), .PIX_DIV(4),
                     .ICG_LOW(20), .ADC_W(12)) dut (
    .Master_clk(Master_clk), .rst(rst), .capture_en(capture_en), .CCD_SH(CCD_SH),
    .clr_status(clr_status), .CCD_ICG(CCD_ICG), .adc_convst(adc_convst), .adc_data(adc_data),
    .pix_data(pix_data), .pix_last(pix_last), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .busy(busy), .frame_done(frame_done), .overflow(overflow), .overrun(overrun));

  always #5 Master_clk = ~Master_clk;

  // ADC model: returns pixel index * 0x111, index taken from the number of strobes this frame.
  always @(posedge Master_clk) conv_seen <= (rst || frame_done) ? 12'd0 : conv_seen + 12'(adc_convst);
  assign adc_data = (conv_seen - 12'd1) * 12'h111;

  always @(negedge Master_clk) begin
    if (pix_valid && pix_ready) got.push_back({pix_last, pix_data});
    if (pv_q && !rdy_q && pix_valid && {pix_last, pix_data} != held) hold_bad++;
    pv_q  = pix_valid;
    rdy_q = pix_ready;
    held  = {pix_last, pix_data};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Master_clk); #1;
  endtask

  // SH rises in cycle 0; sh2 > 0 adds a second SH rise at that cycle offset.
  task automatic run_frame(input int sh2);
    icg_bad = 0; conv_n = 0; conv_bad = 0; done_n = 0; done_at = -1; busy_n = 0;
    CCD_SH = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      tick();
      CCD_SH = (i == sh2);
      if (CCD_ICG == ((i <= 20) && capture_en)) icg_bad++;
      if (adc_convst) begin
        conv_n++;
        if (i < 21 || (i - 21) % 4 != 0) conv_bad++;
      end
      if (frame_done) begin done_n++; done_at = i; end
      if (busy) busy_n++;
    end
  endtask

  task automatic check_line(input int b);
    check("line_words", got.size() - b, 7);
    for (int k = 0; k < 7; k++)
      if (b + k < got.size())
        check($sformatf("word%0d", k), 32'(got[b + k]), 32'({k == 6, 12'((k + 2) * 12'h111)}));
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_icg", CCD_ICG, 1);
    check("rst_convst", adc_convst, 0);
    check("rst_valid", pix_valid, 0);
    check("rst_flags", {pix_last, busy, frame_done, overflow, overrun}, 0);

    base = got.size();
    run_frame(0);
    check("nom_icg", icg_bad, 0);
    check("nom_convst_n", conv_n, 10);
    check("nom_convst_pos", conv_bad, 0);
    check("nom_done_at", done_at, 61);
    check("nom_done_n", done_n, 1);
    check_line(base);

    pix_ready = 1'b0;
    base = got.size();
    run_frame(0);
    check("bp_none_out", got.size() - base, 0);
    check("bp_valid", pix_valid, 1);
    check("bp_head", {pix_last, pix_data}, 13'h222);
    check("bp_overflow", overflow, 1);
    check("bp_hold", hold_bad, 0);
    pix_ready = 1'b1;
    repeat (6) tick();
    check("bp_drain_n", got.size() - base, 4);
    for (int k = 0; k < 4; k++)
      if (base + k < got.size()) check($sformatf("bp_word%0d", k), 32'(got[base + k]), 32'((k + 2) * 12'h111));
    check("bp_empty", pix_valid, 0);
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    check("ovf_clr", overflow, 0);

    base = got.size();
    run_frame(30);
    check("ovr_flag", overrun, 1);
    check("ovr_done_at", done_at, 61);
    check("ovr_convst_n", conv_n, 10);
    check("ovr_icg", icg_bad, 0);
    check_line(base);
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    check("ovr_clr", overrun, 0);

    capture_en = 1'b0;
    run_frame(0);
    check("dis_icg", icg_bad, 0);
    check("dis_convst", conv_n, 0);
    check("dis_busy", busy_n, 0);
    check("dis_ovr", overrun, 0);
    capture_en = 1'b1;

    pix_ready = 1'b0;
    CCD_SH = 1'b1; tick(); CCD_SH = 1'b0;
    repeat (39) tick();
    check("mid_valid", pix_valid, 1);
    check("mid_busy", busy, 1);
    rst = 1'b1; tick();
    check("mid_rst_icg", CCD_ICG, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", pix_valid, 0);
    rst = 1'b0; pix_ready = 1'b1;
    tick();
    base = got.size();
    run_frame(0);
    check("post_done_at", done_at, 61);
    check_line(base);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
